// File: rtl/depacketizer_if.sv
// FIFO read port of the byte-stream depacketizer: 9-bit words, bit 8 set for
// header/payload bytes and clear for the packet terminator.
interface depacketizer_if;
    logic       fifo_empty;
    logic [8:0] fifo_q;
    logic       fifo_rd;

    modport master (input fifo_empty, input fifo_q, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_q, input fifo_rd);
endinterface

// File: rtl/depacketizer.sv
// Splits a framed word stream into pixel lines and control-table writes,
// resynchronising on the 12-byte header and counting protocol errors.
module depacketizer #(
    parameter int CTRL_LEN = 101,
    parameter int LINE_MAX = 1280
) (
    input  logic           clk,
    input  logic           rst,
    depacketizer_if.master fifo,
    input  logic           en,
    output logic [7:0]     pix_data,
    output logic           pix_valid,
    output logic           line_start,
    output logic           line_end,
    output logic [10:0]    line_len,
    output logic           frame_start,
    output logic [7:0]     ctrl_data,
    output logic [6:0]     ctrl_addr,
    output logic           ctrl_we,
    output logic           ctrl_done,
    output logic [7:0]     err_count
);
    typedef enum logic [2:0] {HUNT, HDR, TYPE, DATA, CTRL, DROP} state_t;

    localparam logic [10:0] LineMax = 11'(LINE_MAX);
    localparam logic [10:0] CtrlLen = 11'(CTRL_LEN);

    state_t      state;
    logic        wordVld_p1;
    logic [3:0]  hdrIdx;
    logic [10:0] byteCnt;
    logic        isByte;
    logic [7:0]  wordByte;

    function automatic logic [7:0] hdrByte(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd6:  return 8'h0A;
            4'd1, 4'd7:  return 8'h01;
            4'd2, 4'd8:  return 8'h02;
            4'd3, 4'd9:  return 8'h03;
            4'd4, 4'd10: return 8'h04;
            4'd5:        return 8'h05;
            default:     return 8'hCC;
        endcase
    endfunction

    function automatic logic [7:0] satInc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Read strobe is gated by reset so nothing is pulled from the FIFO while held.
    assign fifo.fifo_rd = rst & en & ~fifo.fifo_empty;
    assign isByte       = fifo.fifo_q[8];
    assign wordByte     = fifo.fifo_q[7:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            wordVld_p1  <= 1'b0;
            hdrIdx      <= '0;
            byteCnt     <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            line_len    <= '0;
            frame_start <= 1'b0;
            ctrl_data   <= '0;
            ctrl_addr   <= '0;
            ctrl_we     <= 1'b0;
            ctrl_done   <= 1'b0;
            err_count   <= '0;
        end else begin
            // p1: FIFO data is valid one cycle after the read strobe
            wordVld_p1  <= fifo.fifo_rd;
            pix_valid   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            frame_start <= 1'b0;
            ctrl_we     <= 1'b0;
            ctrl_done   <= 1'b0;
            // p2: decode the accepted word into registered outputs
            if (wordVld_p1) begin
                unique case (state)
                    HUNT: begin
                        if (isByte && wordByte == 8'h0A) begin
                            state  <= HDR;
                            hdrIdx <= 4'd1;
                        end
                    end
                    HDR: begin
                        if (!isByte) begin
                            state     <= HUNT;
                            err_count <= satInc(err_count);
                        end else if (wordByte == hdrByte(hdrIdx)) begin
                            if (hdrIdx == 4'd11) state <= TYPE;
                            else                 hdrIdx <= hdrIdx + 4'd1;
                        end else if (wordByte == 8'h0A) begin
                            hdrIdx <= 4'd1;
                        end else begin
                            state <= HUNT;
                        end
                    end
                    TYPE: begin
                        byteCnt <= '0;
                        if (!isByte) begin
                            state     <= HUNT;
                            err_count <= satInc(err_count);
                        end else if (wordByte == 8'hFF) begin
                            state <= DATA;
                        end else if (wordByte == 8'h00) begin
                            state       <= CTRL;
                            frame_start <= 1'b1;
                        end else begin
                            state     <= DROP;
                            err_count <= satInc(err_count);
                        end
                    end
                    DATA: begin
                        if (!isByte) begin
                            line_end <= 1'b1;
                            line_len <= byteCnt;
                            state    <= HUNT;
                        end else if (byteCnt == LineMax) begin
                            state     <= DROP;
                            err_count <= satInc(err_count);
                        end else begin
                            pix_data   <= wordByte;
                            pix_valid  <= 1'b1;
                            line_start <= (byteCnt == '0);
                            byteCnt    <= byteCnt + 11'd1;
                        end
                    end
                    CTRL: begin
                        if (!isByte) begin
                            if (byteCnt == CtrlLen) ctrl_done <= 1'b1;
                            else                    err_count <= satInc(err_count);
                            state <= HUNT;
                        end else if (byteCnt == CtrlLen) begin
                            state     <= DROP;
                            err_count <= satInc(err_count);
                        end else begin
                            ctrl_data <= wordByte;
                            ctrl_addr <= byteCnt[6:0];
                            ctrl_we   <= 1'b1;
                            byteCnt   <= byteCnt + 11'd1;
                        end
                    end
                    DROP: begin
                        if (!isByte) state <= HUNT;
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_depacketizer.sv
// Bench for depacketizer: directed packet table, resync/reset sequences and
// randomized traffic against a packet-level reference model.
module tb_depacketizer;
    localparam int CTRL_LEN = 101;
    localparam int LINE_MAX = 1280;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        line_start;
    logic        line_end;
    logic [10:0] line_len;
    logic        frame_start;
    logic [7:0]  ctrl_data;
    logic [6:0]  ctrl_addr;
    logic        ctrl_we;
    logic        ctrl_done;
    logic [7:0]  err_count;

    depacketizer_if fifoIf();

    depacketizer #(.CTRL_LEN(CTRL_LEN), .LINE_MAX(LINE_MAX)) dut (
        .clk(clk), .rst(rst), .fifo(fifoIf), .en(en),
        .pix_data(pix_data), .pix_valid(pix_valid), .line_start(line_start),
        .line_end(line_end), .line_len(line_len), .frame_start(frame_start),
        .ctrl_data(ctrl_data), .ctrl_addr(ctrl_addr), .ctrl_we(ctrl_we),
        .ctrl_done(ctrl_done), .err_count(err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [7:0] typ;
        int         len;
        int         ePix;
        int         eEnd;
        int         eLen;
        int         eCtrl;
        int         eDone;
        int         eFs;
        int         eErr;
    } vec_t;

    logic [7:0] hdrB [12] = '{8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                              8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCC};
    logic [7:0] rsB [17]  = '{8'h0A, 8'h01, 8'h02, 8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                              8'h0A, 8'h01, 8'h02, 8'h03, 8'h04, 8'hCC, 8'hFF, 8'h01};

    logic [8:0]  inQ[$];
    logic [8:0]  pkt[$];
    bit          enReq = 1'b0, stallOn = 1'b0, pauseOn = 1'b0, rdSampled = 1'b0;

    logic [8:0]  monPix[$], expPix[$];
    int          monLen[$], expLen[$];
    logic [14:0] monCtrl[$], expCtrl[$];
    int          monDone = 0, monFs = 0, expDone = 0, expFs = 0, expErr = 0;
    int          overlap = 0, orphanStart = 0;
    int          checks = 0, errors = 0;

    // FIFO model: data appears one cycle after a sampled read strobe
    initial begin
        fifoIf.fifo_empty = 1'b1;
        fifoIf.fifo_q     = '0;
        forever begin
            @(posedge clk);
            rdSampled = fifoIf.fifo_rd;
            @(negedge clk);
            if (rdSampled && inQ.size() > 0) fifoIf.fifo_q = inQ.pop_front();
            fifoIf.fifo_empty = (inQ.size() == 0) || (stallOn && $urandom_range(0, 3) == 0);
            en = enReq && !(pauseOn && $urandom_range(0, 4) == 0);
        end
    end

    initial forever begin
        @(negedge clk);
        if (pix_valid) monPix.push_back({line_start, pix_data});
        else if (line_start) orphanStart++;
        if (line_end) monLen.push_back(int'(line_len));
        if (ctrl_we) monCtrl.push_back({ctrl_addr, ctrl_data});
        if (ctrl_done) monDone++;
        if (frame_start) monFs++;
        if (pix_valid && ctrl_we) overlap++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void bumpErr();
        if (expErr < 255) expErr++;
    endfunction

    // Packet-level reference: find headers, then judge each payload by its length.
    task automatic modelRun();
        int i, j, k, len;
        bit ok;
        logic [8:0] w;
        i = 0;
        while (i < pkt.size()) begin
            if (!(pkt[i][8] && pkt[i][7:0] == 8'h0A)) begin i++; continue; end
            i++; k = 1; ok = 1'b0;
            while (i < pkt.size()) begin
                w = pkt[i]; i++;
                if (!w[8]) begin bumpErr(); break; end
                if (w[7:0] == hdrB[k]) begin
                    if (k == 11) begin ok = 1'b1; break; end
                    k++;
                end else if (w[7:0] == 8'h0A) k = 1;
                else break;
            end
            if (!ok || i >= pkt.size()) continue;
            w = pkt[i]; i++;
            if (!w[8]) begin bumpErr(); continue; end
            j = i;
            while (j < pkt.size() && pkt[j][8]) j++;
            len = j - i;
            if (w[7:0] == 8'hFF) begin
                for (int p = 0; p < len && p < LINE_MAX; p++) expPix.push_back({p == 0, pkt[i+p][7:0]});
                if (len > LINE_MAX) bumpErr(); else expLen.push_back(len);
            end else if (w[7:0] == 8'h00) begin
                expFs++;
                for (int p = 0; p < len && p < CTRL_LEN; p++) expCtrl.push_back({7'(p), pkt[i+p][7:0]});
                if (len == CTRL_LEN) expDone++; else bumpErr();
            end else bumpErr();
            i = j + 1;
        end
    endtask

    task automatic send();
        modelRun();
        foreach (pkt[n]) inQ.push_back(pkt[n]);
        pkt.delete();
    endtask

    task automatic addPacket(input logic [7:0] typ, input int len, input bit rnd);
        foreach (hdrB[n]) pkt.push_back({1'b1, hdrB[n]});
        pkt.push_back({1'b1, typ});
        for (int n = 0; n < len; n++) pkt.push_back({1'b1, rnd ? 8'($urandom) : 8'(n)});
        pkt.push_back(9'h000);
    endtask

    task automatic drain();
        int cyc = 0;
        while (inQ.size() != 0 && cyc < 30000) begin @(negedge clk); cyc++; end
        check("drain", inQ.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic clearLogs();
        monPix.delete(); expPix.delete(); monLen.delete(); expLen.delete();
        monCtrl.delete(); expCtrl.delete();
        monDone = 0; expDone = 0; monFs = 0; expFs = 0;
    endtask

    task automatic checkSeg(input string tag);
        int bad;
        check({tag, ".pixCount"}, monPix.size(), expPix.size());
        bad = 0;
        for (int n = 0; n < monPix.size() && n < expPix.size(); n++) if (monPix[n] !== expPix[n]) bad++;
        check({tag, ".pixMismatches"}, bad, 0);
        check({tag, ".lineEnds"}, monLen.size(), expLen.size());
        bad = 0;
        for (int n = 0; n < monLen.size() && n < expLen.size(); n++) if (monLen[n] != expLen[n]) bad++;
        check({tag, ".lineLenMismatches"}, bad, 0);
        check({tag, ".ctrlCount"}, monCtrl.size(), expCtrl.size());
        bad = 0;
        for (int n = 0; n < monCtrl.size() && n < expCtrl.size(); n++) if (monCtrl[n] !== expCtrl[n]) bad++;
        check({tag, ".ctrlMismatches"}, bad, 0);
        check({tag, ".ctrlDone"}, monDone, expDone);
        check({tag, ".frameStart"}, monFs, expFs);
        check({tag, ".errCount"}, int'(err_count), expErr);
        clearLogs();
    endtask

    task automatic checkResetOutputs(input string tag);
        check({tag, ".fifo_rd"}, int'(fifoIf.fifo_rd), 0);
        check({tag, ".pulses"}, int'({pix_valid, line_start, line_end, frame_start, ctrl_we, ctrl_done}), 0);
        check({tag, ".line_len"}, int'(line_len), 0);
        check({tag, ".err_count"}, int'(err_count), 0);
        check({tag, ".pix_data"}, int'(pix_data), 0);
        check({tag, ".ctrl_data"}, int'(ctrl_data), 0);
        check({tag, ".ctrl_addr"}, int'(ctrl_addr), 0);
    endtask

    initial begin
        vec_t tbl[9];
        int   errRef, lastLen, cyc, k;
        tbl[0] = '{"ramp640",   8'hFF,  640,  640, 1,  640,   0, 0, 0, 0};
        tbl[1] = '{"ctrl101",   8'h00,  101,    0, 0,    0, 101, 1, 1, 0};
        tbl[2] = '{"badType",   8'h7E,   20,    0, 0,    0,   0, 0, 0, 1};
        tbl[3] = '{"afterBad",  8'hFF,    3,    3, 1,    3,   0, 0, 0, 0};
        tbl[4] = '{"ctrlShort", 8'h00,   50,    0, 0,    0,  50, 0, 1, 1};
        tbl[5] = '{"lineOver",  8'hFF, 1281, 1280, 0,    0,   0, 0, 0, 1};
        tbl[6] = '{"emptyLine", 8'hFF,    0,    0, 1,    0,   0, 0, 0, 0};
        tbl[7] = '{"ctrlOver",  8'h00,  102,    0, 0,    0, 101, 0, 1, 1};
        tbl[8] = '{"lineMax",   8'hFF, 1280, 1280, 1, 1280,   0, 0, 0, 0};

        #1 rst = 1'b0;
        pkt.push_back(9'h1AA); pkt.push_back(9'h000);
        send();
        enReq = 1'b1;
        @(negedge clk); @(negedge clk); #1;
        checkResetOutputs("reset");
        @(posedge clk); #2 rst = 1'b1;
        drain();
        checkSeg("junk");

        errRef = 0; lastLen = 0;
        foreach (tbl[v]) begin
            addPacket(tbl[v].typ, tbl[v].len, 1'b0);
            send();
            drain();
            errRef += tbl[v].eErr;
            if (tbl[v].eEnd != 0) lastLen = tbl[v].eLen;
            check({tbl[v].name, ".tblPix"}, monPix.size(), tbl[v].ePix);
            check({tbl[v].name, ".tblLineEnd"}, monLen.size(), tbl[v].eEnd);
            check({tbl[v].name, ".tblLineLen"}, int'(line_len), lastLen);
            check({tbl[v].name, ".tblCtrl"}, monCtrl.size(), tbl[v].eCtrl);
            check({tbl[v].name, ".tblDone"}, monDone, tbl[v].eDone);
            check({tbl[v].name, ".tblFrame"}, monFs, tbl[v].eFs);
            check({tbl[v].name, ".tblErr"}, int'(err_count), errRef);
            checkSeg(tbl[v].name);
        end

        foreach (rsB[n]) pkt.push_back({1'b1, rsB[n]});
        pkt.push_back(9'h000);
        send();
        drain();
        check("resync.pixCount", monPix.size(), 1);
        check("resync.pixWord", (monPix.size() > 0) ? int'(monPix[0]) : -1, 9'h101);
        check("resync.lineLen", int'(line_len), 1);
        checkSeg("resync");

        stallOn = 1'b1; pauseOn = 1'b1;
        addPacket(8'hFF, 640, 1'b0);
        send();
        drain();
        check("rampStall.lineLen", int'(line_len), 640);
        checkSeg("rampStall");

        for (int s = 0; s < 40; s++) begin
            case ($urandom_range(0, 7))
                0, 1, 2: addPacket(8'hFF, $urandom_range(0, 40), 1'b1);
                3:       addPacket(8'h00, CTRL_LEN, 1'b1);
                4:       addPacket(8'h00, $urandom_range(0, 110), 1'b1);
                5:       addPacket(8'($urandom_range(1, 254)), $urandom_range(0, 10), 1'b1);
                6: begin
                    k = $urandom_range(1, 11);
                    for (int n = 0; n < k; n++) pkt.push_back({1'b1, hdrB[n]});
                    for (int n = 0; n < 6; n++) pkt.push_back(9'($urandom));
                    pkt.push_back(9'h000);
                end
                default: begin
                    pkt.push_back(9'h10A); pkt.push_back(9'h101);
                    addPacket(8'hFF, $urandom_range(1, 20), 1'b1);
                end
            endcase
            send();
        end
        drain();
        checkSeg("random");

        stallOn = 1'b0; pauseOn = 1'b0;
        addPacket(8'hFF, 300, 1'b0);
        send();
        cyc = 0;
        while (monPix.size() < 50 && cyc < 2000) begin @(negedge clk); cyc++; end
        check("midReset.reachedData", int'(monPix.size() >= 50), 1);
        @(posedge clk); #2 rst = 1'b0;
        inQ.delete();
        #1;
        checkResetOutputs("midReset");
        clearLogs();
        expErr = 0;
        repeat (2) @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        addPacket(8'hFF, 64, 1'b1);
        send();
        drain();
        check("afterReset.lineLen", int'(line_len), 64);
        checkSeg("afterReset");

        for (int s = 0; s < 260; s++) begin
            addPacket(8'h7E, 0, 1'b0);
            send();
        end
        addPacket(8'h00, CTRL_LEN, 1'b1);
        send();
        drain();
        check("saturate.err", int'(err_count), 255);
        checkSeg("saturate");

        check("pixCtrlOverlap", overlap, 0);
        check("orphanLineStart", orphanStart, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
